// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage for the decode pipe: decodes the immediate of the incoming
// instruction and buffers {imm, tag, illegal} in a small valid/ready FIFO with flush.
module imm_ext_pipe #(
   parameter int XLEN   = 32,
   parameter int RVC_EN = 1,
   parameter int DEPTH  = 2,
   parameter int TAG_W  = 5
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [31:0]                instr_i,
   input  logic [3:0]                 immType_i,
   input  logic [TAG_W-1:0]           tag_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [XLEN-1:0]            imm_o,
   output logic [TAG_W-1:0]           tag_o,
   output logic                       illegal_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   localparam logic [3:0] T_NO    = 4'd0;
   localparam logic [3:0] T_I     = 4'd1;
   localparam logic [3:0] T_S     = 4'd2;
   localparam logic [3:0] T_B     = 4'd3;
   localparam logic [3:0] T_U     = 4'd4;
   localparam logic [3:0] T_J     = 4'd5;
   localparam logic [3:0] T_Z     = 4'd6;
   localparam logic [3:0] T_CI    = 4'd8;
   localparam logic [3:0] T_CLUI  = 4'd9;
   localparam logic [3:0] T_C16SP = 4'd10;
   localparam logic [3:0] T_CIW   = 4'd11;
   localparam logic [3:0] T_CLSW  = 4'd12;
   localparam logic [3:0] T_CJ    = 4'd13;
   localparam logic [3:0] T_CB    = 4'd14;

   logic [31:0]      ins;
   logic [31:0]      imm32;
   logic             illegal_d;
   logic             rvc_ok;
   logic [XLEN-1:0]  imm_ext;
   logic             unused_opcode;

   assign ins           = instr_i;
   assign rvc_ok        = (RVC_EN != 0);
   assign unused_opcode = ^instr_i[1:0];

   // imm32 holds the value already extended to 32 bits; zero-extended types keep bit 31 clear,
   // so widening to 64 bits by replicating bit 31 is correct for every type.
   always_comb begin
      imm32     = 32'h0;
      illegal_d = 1'b0;
      case (immType_i)
         T_NO:    imm32 = 32'h0;
         T_I:     imm32 = {{20{ins[31]}}, ins[31:20]};
         T_S:     imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         T_B:     imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         T_U:     imm32 = {ins[31:12], 12'h000};
         T_J:     imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         T_Z:     imm32 = {27'h0, ins[19:15]};
         T_CI:    imm32 = {{26{ins[12]}}, ins[12], ins[6:2]};
         T_CLUI:  imm32 = {{14{ins[12]}}, ins[12], ins[6:2], 12'h000};
         T_C16SP: imm32 = {{22{ins[12]}}, ins[12], ins[4:3], ins[5], ins[2], ins[6], 4'h0};
         T_CIW:   imm32 = {22'h0, ins[10:7], ins[12:11], ins[5], ins[6], 2'b00};
         T_CLSW:  imm32 = {25'h0, ins[5], ins[12:10], ins[6], 2'b00};
         T_CJ:    imm32 = {{20{ins[12]}}, ins[12], ins[8], ins[10:9], ins[6], ins[7], ins[2],
                           ins[11], ins[5:3], 1'b0};
         T_CB:    imm32 = {{23{ins[12]}}, ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0};
         default: begin
            imm32     = 32'h0;
            illegal_d = 1'b1;
         end
      endcase
      if (!rvc_ok && immType_i[3] && (immType_i != 4'd15)) begin
         imm32     = 32'h0;
         illegal_d = 1'b1;
      end
   end

   generate
      if (XLEN == 64) begin : g_x64
         assign imm_ext = {{32{imm32[31]}}, imm32};
      end else begin : g_x32
         assign imm_ext = imm32;
      end
   endgenerate

   logic [XLEN-1:0]  imm_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic             ill_mem [DEPTH];

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push;
   logic             pop;

   // valid/ready: a transfer happens on an edge where both are high; ready_o and valid_o
   // depend only on the registered occupancy, so neither side sees a combinational path.
   assign ready_o = (count_q != CNT_W'(DEPTH));
   assign valid_o = (count_q != '0);
   assign push    = valid_i && ready_o;
   assign pop     = valid_o && ready_i;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (rst_i || flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PTR_W'(1);
         if (pop)  rptr_d = rptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Payload is not reset; a write dropped by flush/reset is never exposed since wptr does not move.
   always_ff @(posedge clk_i) begin
      if (push) begin
         imm_mem[wptr_q] <= imm_ext;
         tag_mem[wptr_q] <= tag_i;
         ill_mem[wptr_q] <= illegal_d;
      end
   end

   assign imm_o     = imm_mem[rptr_q];
   assign tag_o     = tag_mem[rptr_q];
   assign illegal_o = ill_mem[rptr_q];
   assign count_o   = count_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: three instances (default, XLEN=64, RVC_EN=0) share one stimulus stream;
// expected entries are queued on acceptance and compared against the head of each instance.
module tb_imm_ext_pipe;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic [31:0] imm_a;
      logic [63:0] imm_b;
      logic [31:0] imm_c;
      logic        ill_a;
      logic        ill_c;
      logic [4:0]  tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, flush, valid_in, ready_in;
   logic [31:0] instr;
   logic [3:0]  itype;
   logic [4:0]  tag;

   logic        rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c, ill_a, ill_b, ill_c;
   logic [31:0] imm_a, imm_c;
   logic [63:0] imm_b;
   logic [4:0]  tag_a, tag_b, tag_c;
   logic [1:0]  cnt_a, cnt_b, cnt_c;

   exp_t exp_q[$];
   exp_t cur;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   imm_ext_pipe #(.XLEN(32), .RVC_EN(1), .DEPTH(DEPTH), .TAG_W(5)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in), .ready_o(rdy_a),
      .instr_i(instr), .immType_i(itype), .tag_i(tag), .valid_o(vld_a), .ready_i(ready_in),
      .imm_o(imm_a), .tag_o(tag_a), .illegal_o(ill_a), .count_o(cnt_a));

   imm_ext_pipe #(.XLEN(64), .RVC_EN(1), .DEPTH(DEPTH), .TAG_W(5)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in), .ready_o(rdy_b),
      .instr_i(instr), .immType_i(itype), .tag_i(tag), .valid_o(vld_b), .ready_i(ready_in),
      .imm_o(imm_b), .tag_o(tag_b), .illegal_o(ill_b), .count_o(cnt_b));

   imm_ext_pipe #(.XLEN(32), .RVC_EN(0), .DEPTH(DEPTH), .TAG_W(5)) u_dut_c (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_in), .ready_o(rdy_c),
      .instr_i(instr), .immType_i(itype), .tag_i(tag), .valid_o(vld_c), .ready_i(ready_in),
      .imm_o(imm_c), .tag_o(tag_c), .illegal_o(ill_c), .count_o(cnt_c));

   // Reference extension: returns {illegal, imm sign/zero-extended to 64 bits}.
   function automatic logic [64:0] ref_ext(input logic [3:0] t, input logic [31:0] x, input bit rvc);
      logic [63:0] v;
      logic        il;
      v  = 64'h0;
      il = 1'b0;
      if (t >= 4'd8 && t <= 4'd14 && !rvc) begin
         il = 1'b1;
      end else begin
         case (t)
            4'd0:  v = 64'h0;
            4'd1:  v = 64'($signed(x[31:20]));
            4'd2:  v = 64'($signed({x[31:25], x[11:7]}));
            4'd3:  v = 64'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
            4'd4:  v = 64'($signed({x[31:12], 12'h000}));
            4'd5:  v = 64'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
            4'd6:  v = 64'(x[19:15]);
            4'd8:  v = 64'($signed({x[12], x[6:2]}));
            4'd9:  v = 64'($signed({x[12], x[6:2], 12'h000}));
            4'd10: v = 64'($signed({x[12], x[4:3], x[5], x[2], x[6], 4'h0}));
            4'd11: v = 64'({x[10:7], x[12:11], x[5], x[6], 2'b00});
            4'd12: v = 64'({x[5], x[12:10], x[6], 2'b00});
            4'd13: v = 64'($signed({x[12], x[8], x[10:9], x[6], x[7], x[2], x[11], x[5:3], 1'b0}));
            4'd14: v = 64'($signed({x[12], x[6:5], x[2], x[11:10], x[4:3], 1'b0}));
            default: il = 1'b1;
         endcase
      end
      return {il, v};
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic drive_dir(input logic [3:0] t, input logic [31:0] x, input logic [4:0] tg,
                            input logic [31:0] ea, input logic [63:0] eb, input logic [31:0] ec,
                            input logic ila, input logic ilc);
      itype    = t;
      instr    = x;
      tag      = tg;
      valid_in = 1'b1;
      cur      = '{imm_a: ea, imm_b: eb, imm_c: ec, ill_a: ila, ill_c: ilc, tag: tg};
   endtask

   task automatic drive_rand(input logic [3:0] t, input logic [31:0] x, input logic [4:0] tg);
      logic [64:0] r1, r0;
      r1 = ref_ext(t, x, 1'b1);
      r0 = ref_ext(t, x, 1'b0);
      itype    = t;
      instr    = x;
      tag      = tg;
      valid_in = 1'b1;
      cur      = '{imm_a: r1[31:0], imm_b: r1[63:0], imm_c: r0[31:0],
                   ill_a: r1[64], ill_c: r0[64], tag: tg};
   endtask

   task automatic check_outputs();
      int n;
      n = exp_q.size();
      chk("count_a", 64'(cnt_a), 64'(n));
      chk("count_b", 64'(cnt_b), 64'(n));
      chk("count_c", 64'(cnt_c), 64'(n));
      chk("ready_a", 64'(rdy_a), 64'(n != DEPTH));
      chk("ready_c", 64'(rdy_c), 64'(n != DEPTH));
      chk("valid_a", 64'(vld_a), 64'(n != 0));
      chk("valid_b", 64'(vld_b), 64'(n != 0));
      if (n != 0) begin
         chk("imm_a", 64'(imm_a), 64'(exp_q[0].imm_a));
         chk("imm_b", imm_b, exp_q[0].imm_b);
         chk("imm_c", 64'(imm_c), 64'(exp_q[0].imm_c));
         chk("tag_a", 64'(tag_a), 64'(exp_q[0].tag));
         chk("tag_c", 64'(tag_c), 64'(exp_q[0].tag));
         chk("ill_a", 64'(ill_a), 64'(exp_q[0].ill_a));
         chk("ill_b", 64'(ill_b), 64'(exp_q[0].ill_a));
         chk("ill_c", 64'(ill_c), 64'(exp_q[0].ill_c));
      end
   endtask

   // One clock: update the scoreboard with what the edge does, then compare just after it.
   task automatic tick();
      bit do_push, do_pop;
      @(posedge clk);
      if (rst || flush) begin
         exp_q.delete();
      end else begin
         do_pop  = (exp_q.size() != 0) && ready_in;
         do_push = valid_in && (exp_q.size() != DEPTH);
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(cur);
      end
      #1;
      check_outputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
      instr = 32'h0; itype = 4'd0; tag = 5'd0; cur = '0;
      tick();
      tick();
      rst = 1'b0;

      // Directed vectors, streaming with ready_i high: latency 1, count holds at 1.
      ready_in = 1'b1;
      drive_dir(4'd1, 32'hFFF00093, 5'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      tick();
      drive_dir(4'd3, 32'hFE000EE3, 5'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 1'b0, 1'b0);
      tick();
      drive_dir(4'd4, 32'h800000B7, 5'd3, 32'h80000000, 64'hFFFFFFFF80000000, 32'h80000000, 1'b0, 1'b0);
      tick();
      drive_dir(4'd6, 32'h000F8073, 5'd4, 32'h1F, 64'h1F, 32'h1F, 1'b0, 1'b0);
      tick();
      drive_dir(4'd13, 32'h0000BFFD, 5'd5, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 32'h0, 1'b0, 1'b1);
      tick();
      drive_dir(4'd7, 32'hFFFFFFFF, 5'd6, 32'h0, 64'h0, 32'h0, 1'b1, 1'b1);
      tick();
      drive_dir(4'd15, 32'hFFFFFFFF, 5'd7, 32'h0, 64'h0, 32'h0, 1'b1, 1'b1);
      tick();
      drive_dir(4'd0, 32'hFFFFFFFF, 5'd8, 32'h0, 64'h0, 32'h0, 1'b0, 1'b0);
      tick();
      valid_in = 1'b0;
      tick();

      // Backpressure: two accepted, third held until the first pop.
      ready_in = 1'b0;
      drive_rand(4'd2, $urandom, 5'd10);
      tick();
      drive_rand(4'd8, $urandom, 5'd11);
      tick();
      drive_rand(4'd14, $urandom, 5'd12);
      tick();
      tick();
      ready_in = 1'b1;
      tick();
      tick();
      valid_in = 1'b0;
      tick();

      // Flush with one entry queued and a same-cycle push.
      ready_in = 1'b0;
      drive_rand(4'd5, $urandom, 5'd20);
      tick();
      drive_rand(4'd9, $urandom, 5'd21);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      valid_in = 1'b0;
      tick();

      // Reset while full, then a fresh entry flows normally.
      drive_rand(4'd10, $urandom, 5'd30);
      tick();
      drive_rand(4'd11, $urandom, 5'd31);
      tick();
      drive_rand(4'd12, $urandom, 5'd32);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive_rand(4'd13, $urandom, 5'd33);
      tick();
      valid_in = 1'b0;
      ready_in = 1'b1;
      tick();

      // Random traffic with occasional flushes.
      for (int i = 0; i < 80; i++) begin
         drive_rand(4'($urandom_range(0, 15)), $urandom, 5'($urandom_range(0, 31)));
         valid_in = 1'($urandom_range(0, 1));
         ready_in = 1'($urandom_range(0, 1));
         flush    = ($urandom_range(0, 15) == 0);
         tick();
      end
      flush = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      tick();
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
